// File: rtl/buraq_if_aligner.sv
// buraq_if_aligner: splits aligned 32-bit fetch words into 16-bit parcels and
// reassembles one RV32IMC instruction per handshake into a registered output.
module buraq_if_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_cmp_o,
    output logic [31:0] instr_pc_o
);

    // Where the parcel(s) for the current emit come from, in priority order.
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_HOLD_CMP,
        SRC_HOLD_STRADDLE,
        SRC_UPPER,
        SRC_WORD
    } src_e;

    localparam logic [31:0] BOOT_PC = BOOT_ADDR & ~32'd1;

    logic [15:0] hold_q, hold_d;
    logic        hold_v_q, hold_v_d;
    logic        skip_q, skip_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        cmp_q, cmp_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;

    logic        load;
    logic        emit;
    logic [31:0] e_instr;
    logic        e_cmp;
    logic        ready;
    src_e        src;

    assign load = !valid_q || instr_ready_i;

    // Source selection, next-state and fetch handshake.
    always_comb begin
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        skip_d   = skip_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        cmp_d    = cmp_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        ready    = 1'b0;
        emit     = 1'b0;
        e_instr  = '0;
        e_cmp    = 1'b0;
        src      = SRC_NONE;

        if (hold_v_q && hold_q[1:0] != 2'b11) begin
            src = SRC_HOLD_CMP;
        end else if (hold_v_q) begin
            if (fetch_valid_i) src = SRC_HOLD_STRADDLE;
        end else if (fetch_valid_i) begin
            src = skip_q ? SRC_UPPER : SRC_WORD;
        end

        case (src)
            SRC_HOLD_CMP: begin
                emit    = 1'b1;
                e_instr = {16'b0, hold_q};
                e_cmp   = 1'b1;
                if (load) hold_v_d = 1'b0;
            end
            SRC_HOLD_STRADDLE: begin
                emit    = 1'b1;
                e_instr = {fetch_rdata_i[15:0], hold_q};
                ready   = load;
                if (load) hold_d = fetch_rdata_i[31:16];
            end
            SRC_UPPER: begin
                if (fetch_rdata_i[17:16] != 2'b11) begin
                    emit    = 1'b1;
                    e_instr = {16'b0, fetch_rdata_i[31:16]};
                    e_cmp   = 1'b1;
                    ready   = load;
                    if (load) skip_d = 1'b0;
                end else begin
                    // Parking the upper half needs no output slot, so the
                    // word is taken even under backpressure.
                    ready    = 1'b1;
                    hold_d   = fetch_rdata_i[31:16];
                    hold_v_d = 1'b1;
                    skip_d   = 1'b0;
                end
            end
            SRC_WORD: begin
                emit  = 1'b1;
                ready = load;
                if (fetch_rdata_i[1:0] != 2'b11) begin
                    e_instr = {16'b0, fetch_rdata_i[15:0]};
                    e_cmp   = 1'b1;
                    if (load) begin
                        hold_d   = fetch_rdata_i[31:16];
                        hold_v_d = 1'b1;
                    end
                end else begin
                    e_instr = fetch_rdata_i;
                end
            end
            default: ;
        endcase

        if (load) begin
            valid_d = emit;
            if (emit) begin
                instr_d = e_instr;
                cmp_d   = e_cmp;
                ipc_d   = pc_q;
                pc_d    = pc_q + (e_cmp ? 32'd2 : 32'd4);
            end
        end

        if (flush_i) begin
            valid_d  = 1'b0;
            hold_v_d = 1'b0;
            pc_d     = flush_pc_i & ~32'd1;
            skip_d   = flush_pc_i[1];
            ready    = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            skip_q   <= BOOT_ADDR[1];
            pc_q     <= BOOT_PC;
            instr_q  <= '0;
            cmp_q    <= 1'b0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            skip_q   <= skip_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            cmp_q    <= cmp_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
        end
    end

    assign fetch_ready_o = ready && rst_ni;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_cmp_o   = cmp_q;
    assign instr_pc_o    = ipc_q;

endmodule

// File: tb/tb_buraq_if_aligner.sv
// Directed bench for buraq_if_aligner with hand-computed expectations.
module tb_buraq_if_aligner;

    logic        clk;
    logic        rst_n;
    logic        fv;
    logic [31:0] w;
    logic        fetch_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ivalid;
    logic        iready;
    logic [31:0] instr;
    logic        icmp;
    logic [31:0] ipc;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    buraq_if_aligner #(.BOOT_ADDR(32'h8000_0000)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_valid_i (fv),
        .fetch_rdata_i (w),
        .fetch_ready_o (fetch_ready),
        .flush_i       (flush),
        .flush_pc_i    (flush_pc),
        .instr_valid_o (ivalid),
        .instr_ready_i (iready),
        .instr_o       (instr),
        .instr_cmp_o   (icmp),
        .instr_pc_o    (ipc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] i, input logic c, input logic [31:0] p);
        check_eq({tag, ".valid"}, {31'b0, ivalid}, 32'd1);
        check_eq({tag, ".instr"}, instr, i);
        check_eq({tag, ".cmp"}, {31'b0, icmp}, {31'b0, c});
        check_eq({tag, ".pc"}, ipc, p);
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush    = 1'b1;
        flush_pc = target;
        settle();
        check_eq("flush_ready", {31'b0, fetch_ready}, 32'd0);
        tick();
        flush = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        fv       = 1'b1;
        w        = 32'h00A0_0093;
        flush    = 1'b0;
        flush_pc = '0;
        iready   = 1'b1;
        #2;
        check_eq("rst_valid", {31'b0, ivalid}, 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_cmp", {31'b0, icmp}, 32'd0);
        check_eq("rst_pc", ipc, 32'd0);
        check_eq("rst_ready", {31'b0, fetch_ready}, 32'd0);
        tick();
        tick();
        rst_n = 1'b0;
        rst_n = 1'b1;

        // Straight-line 32-bit instruction at the boot address.
        settle();
        check_eq("s32_ready", {31'b0, fetch_ready}, 32'd1);
        tick();
        fv = 1'b0;
        expect_out("s32", 32'h00A0_0093, 1'b0, 32'h8000_0000);

        // Two compressed in one word: D then A, word held in the second cycle.
        fv = 1'b1;
        w  = 32'h4505_0001;
        settle();
        check_eq("cc_ready0", {31'b0, fetch_ready}, 32'd1);
        tick();
        expect_out("cc0", 32'h0000_0001, 1'b1, 32'h8000_0004);
        w = 32'h0093_0001;
        settle();
        check_eq("cc_ready1", {31'b0, fetch_ready}, 32'd0);
        tick();
        expect_out("cc1", 32'h0000_4505, 1'b1, 32'h8000_0006);

        // Straddle: c.nop, 32-bit across the boundary, then c.nop; no bubbles.
        settle();
        check_eq("st_ready0", {31'b0, fetch_ready}, 32'd1);
        tick();
        expect_out("st0", 32'h0000_0001, 1'b1, 32'h8000_0008);
        w = 32'h0001_00A0;
        settle();
        check_eq("st_ready1", {31'b0, fetch_ready}, 32'd1);
        tick();
        expect_out("st1", 32'h00A0_0093, 1'b0, 32'h8000_000A);
        fv = 1'b0;
        tick();
        expect_out("st2", 32'h0000_0001, 1'b1, 32'h8000_000E);

        // Backpressure for three cycles with a held parcel behind the output.
        fv = 1'b1;
        w  = 32'h4505_0001;
        tick();
        expect_out("bp0", 32'h0000_0001, 1'b1, 32'h8000_0010);
        iready = 1'b0;
        w      = 32'h00A0_0093;
        for (int unsigned i = 0; i < 3; i++) begin
            settle();
            check_eq("bp_ready", {31'b0, fetch_ready}, 32'd0);
            tick();
            expect_out("bp_hold", 32'h0000_0001, 1'b1, 32'h8000_0010);
        end
        iready = 1'b1;
        settle();
        check_eq("bp_rel_ready", {31'b0, fetch_ready}, 32'd0);
        tick();
        expect_out("bp1", 32'h0000_4505, 1'b1, 32'h8000_0012);
        tick();
        fv = 1'b0;
        expect_out("bp2", 32'h00A0_0093, 1'b0, 32'h8000_0014);

        // Misaligned flush: low half of the first word is skipped.
        fv = 1'b1;
        w  = 32'hDEAD_BEEF;
        do_flush(32'h8000_0102);
        check_eq("mf_valid", {31'b0, ivalid}, 32'd0);
        w = 32'h4505_0001;
        settle();
        check_eq("mf_ready", {31'b0, fetch_ready}, 32'd1);
        tick();
        fv = 1'b0;
        expect_out("mf", 32'h0000_4505, 1'b1, 32'h8000_0102);
        tick();
        check_eq("mf_drain", {31'b0, ivalid}, 32'd0);

        // Misaligned flush onto a 32-bit upper half: parked, then straddled.
        fv = 1'b1;
        w  = 32'h0093_1234;
        do_flush(32'h8000_0202);
        settle();
        check_eq("mu_ready", {31'b0, fetch_ready}, 32'd1);
        tick();
        check_eq("mu_noemit", {31'b0, ivalid}, 32'd0);
        w = 32'h0001_00A0;
        tick();
        fv = 1'b0;
        expect_out("mu0", 32'h00A0_0093, 1'b0, 32'h8000_0202);
        tick();
        expect_out("mu1", 32'h0000_0001, 1'b1, 32'h8000_0206);

        // Flush while stalled with a held parcel drops both.
        fv = 1'b1;
        w  = 32'h4505_0001;
        do_flush(32'h8000_0300);
        tick();
        expect_out("fs0", 32'h0000_0001, 1'b1, 32'h8000_0300);
        iready = 1'b0;
        fv     = 1'b0;
        tick();
        do_flush(32'h8000_0400);
        check_eq("fs_valid", {31'b0, ivalid}, 32'd0);
        iready = 1'b1;
        fv     = 1'b1;
        w      = 32'h00A0_0093;
        settle();
        check_eq("fs_ready", {31'b0, fetch_ready}, 32'd1);
        tick();
        fv = 1'b0;
        expect_out("fs1", 32'h00A0_0093, 1'b0, 32'h8000_0400);

        // PC wrap from the top halfword.
        fv = 1'b1;
        w  = 32'h0001_1234;
        do_flush(32'hFFFF_FFFE);
        tick();
        expect_out("wr0", 32'h0000_0001, 1'b1, 32'hFFFF_FFFE);
        w = 32'h00A0_0093;
        tick();
        fv = 1'b0;
        expect_out("wr1", 32'h00A0_0093, 1'b0, 32'h0000_0000);

        // Reset in the middle of a straddle discards the held parcel.
        fv = 1'b1;
        w  = 32'h0093_0001;
        do_flush(32'h8000_0500);
        tick();
        expect_out("mr0", 32'h0000_0001, 1'b1, 32'h8000_0500);
        fv    = 1'b0;
        rst_n = 1'b0;
        settle();
        check_eq("mr_valid", {31'b0, ivalid}, 32'd0);
        check_eq("mr_ready", {31'b0, fetch_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        fv    = 1'b1;
        w     = 32'h00A0_0093;
        tick();
        fv = 1'b0;
        expect_out("mr1", 32'h00A0_0093, 1'b0, 32'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
